// File: rtl/ttl_gen_pkg.sv
// Shared types and constants for the TTL pulse generator bank.
package ttl_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } chan_state_e;

  localparam int SHADOW_PERIOD_RST = 2;
  localparam int SHADOW_HIGH_RST   = 1;
  localparam int SHADOW_BURST_RST  = 0;

  function automatic chan_state_e phase_state(input logic below_high);
    return below_high ? HIGH : LOW;
  endfunction

endpackage

// File: rtl/ttl_pulse_chan.sv
// One pulse channel: shadow/active config, enable edge detect, IDLE/HIGH/LOW FSM
// and registered output steering onto one of two lines.
module ttl_pulse_chan
  import ttl_gen_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cfg_wr_i,
  input  logic [CNT_W-1:0]   cfg_period_i,
  input  logic [CNT_W-1:0]   cfg_high_i,
  input  logic [BURST_W-1:0] cfg_burst_i,
  input  logic               branch_i,
  input  logic               enable_i,
  output logic               out_0_o,
  output logic               out_1_o,
  output logic               busy_o,
  output logic               done_o
);

  logic [CNT_W-1:0]   shd_period_q, shd_high_q;
  logic [BURST_W-1:0] shd_burst_q;

  logic [CNT_W-1:0]   act_period_q, act_period_d;
  logic [CNT_W-1:0]   act_high_q, act_high_d;
  logic [BURST_W-1:0] act_burst_q, act_burst_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               branch_q, branch_d;
  logic               fin_q, fin_d;
  logic               en_prev_q;
  chan_state_e        state_q, state_d;

  logic               out_0_q, out_1_q, busy_q, done_q;

  logic               start_s;
  logic               period_end_s;
  logic [CNT_W-1:0]   cnt_inc_s;

  // Shadow config; a zero period is not a legal setting and leaves it untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shd_period_q <= CNT_W'(SHADOW_PERIOD_RST);
      shd_high_q   <= CNT_W'(SHADOW_HIGH_RST);
      shd_burst_q  <= BURST_W'(SHADOW_BURST_RST);
    end else if (cfg_wr_i && (cfg_period_i != {CNT_W{1'b0}})) begin
      shd_period_q <= cfg_period_i;
      shd_high_q   <= cfg_high_i;
      shd_burst_q  <= cfg_burst_i;
    end else begin
      shd_period_q <= shd_period_q;
      shd_high_q   <= shd_high_q;
      shd_burst_q  <= shd_burst_q;
    end
  end

  // Next-state logic for the pulse FSM and its counters.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    fin_d        = 1'b0;
    act_period_d = act_period_q;
    act_high_d   = act_high_q;
    act_burst_d  = act_burst_q;
    branch_d     = branch_q;
    start_s      = enable_i & ~en_prev_q;
    cnt_inc_s    = cnt_q + CNT_W'(1);
    period_end_s = (cnt_q == (act_period_q - CNT_W'(1)));

    case (state_q)
      IDLE: begin
        if (start_s) begin
          act_period_d = shd_period_q;
          act_high_d   = shd_high_q;
          act_burst_d  = shd_burst_q;
          rem_d        = shd_burst_q;
          branch_d     = branch_i;
          cnt_d        = {CNT_W{1'b0}};
          state_d      = phase_state(shd_high_q != {CNT_W{1'b0}});
        end else begin
          state_d = IDLE;
        end
      end
      HIGH, LOW: begin
        if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (period_end_s) begin
          cnt_d = {CNT_W{1'b0}};
          // A nonzero burst ends once its last period completes.
          if ((act_burst_q != {BURST_W{1'b0}}) && (rem_q == BURST_W'(1))) begin
            state_d = IDLE;
            fin_d   = 1'b1;
          end else if (act_burst_q != {BURST_W{1'b0}}) begin
            rem_d   = rem_q - BURST_W'(1);
            state_d = phase_state(act_high_q != {CNT_W{1'b0}});
          end else begin
            state_d = phase_state(act_high_q != {CNT_W{1'b0}});
          end
        end else begin
          cnt_d   = cnt_inc_s;
          state_d = phase_state(cnt_inc_s < act_high_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM, counters, latched config and enable history.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      rem_q        <= {BURST_W{1'b0}};
      fin_q        <= 1'b0;
      act_period_q <= CNT_W'(SHADOW_PERIOD_RST);
      act_high_q   <= CNT_W'(SHADOW_HIGH_RST);
      act_burst_q  <= BURST_W'(SHADOW_BURST_RST);
      branch_q     <= 1'b0;
      en_prev_q    <= 1'b1;  // an enable already high at release must not start
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      fin_q        <= fin_d;
      act_period_q <= act_period_d;
      act_high_q   <= act_high_d;
      act_burst_q  <= act_burst_d;
      branch_q     <= branch_d;
      en_prev_q    <= enable_i;
    end
  end

  // Registered output stage, one cycle behind the FSM.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_0_q <= 1'b0;
      out_1_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      out_0_q <= (state_q == HIGH) & ~branch_q;
      out_1_q <= (state_q == HIGH) & branch_q;
      busy_q  <= (state_q != IDLE);
      done_q  <= fin_q;
    end
  end

  assign out_0_o = out_0_q;
  assign out_1_o = out_1_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: rtl/gener_ttl_out_bank.sv
// Bank of independent TTL pulse channels with config-write decode.
module gener_ttl_out_bank
  import ttl_gen_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk_100Mz,
  input  logic               rst_n,
  input  logic               cfg_wr,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic [N_CH-1:0]    branch_channel,
  input  logic [N_CH-1:0]    enable_channel,
  output logic [N_CH-1:0]    data_out_0,
  output logic [N_CH-1:0]    data_out_1,
  output logic [N_CH-1:0]    busy,
  output logic [N_CH-1:0]    done
);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_chan
      // Only indices below N_CH exist, so out-of-range channel writes match nothing.
      logic wr_s;
      assign wr_s = cfg_wr && (cfg_ch == CH_W'(gi));

      ttl_pulse_chan #(
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
      ) u_chan (
        .clk_i        (clk_100Mz),
        .rst_n_i      (rst_n),
        .cfg_wr_i     (wr_s),
        .cfg_period_i (cfg_period),
        .cfg_high_i   (cfg_high),
        .cfg_burst_i  (cfg_burst),
        .branch_i     (branch_channel[gi]),
        .enable_i     (enable_channel[gi]),
        .out_0_o      (data_out_0[gi]),
        .out_1_o      (data_out_1[gi]),
        .busy_o       (busy[gi]),
        .done_o       (done[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_gener_ttl_out_bank.sv
// Directed self-checking bench for gener_ttl_out_bank.
module tb_gener_ttl_out_bank;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int BW = 8;

  logic          clk_100Mz = 1'b0;
  logic          rst_n;
  logic          cfg_wr;
  logic [1:0]    cfg_ch;
  logic [CW-1:0] cfg_period;
  logic [CW-1:0] cfg_high;
  logic [BW-1:0] cfg_burst;
  logic [N-1:0]  branch_channel;
  logic [N-1:0]  enable_channel;
  logic [N-1:0]  data_out_0;
  logic [N-1:0]  data_out_1;
  logic [N-1:0]  busy;
  logic [N-1:0]  done;

  int checks   = 0;
  int failures = 0;

  // Expected per-channel config used by the reference model.
  int           cp[N];
  int           chh[N];
  int           cb[N];
  logic [N-1:0] cbr;
  logic [N-1:0] cact;

  gener_ttl_out_bank #(.N_CH(N), .CNT_W(CW), .BURST_W(BW)) dut (
    .clk_100Mz      (clk_100Mz),
    .rst_n          (rst_n),
    .cfg_wr         (cfg_wr),
    .cfg_ch         (cfg_ch),
    .cfg_period     (cfg_period),
    .cfg_high       (cfg_high),
    .cfg_burst      (cfg_burst),
    .branch_channel (branch_channel),
    .enable_channel (enable_channel),
    .data_out_0     (data_out_0),
    .data_out_1     (data_out_1),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk_100Mz = ~clk_100Mz;

  // t = cycles since the first expected high-phase cycle; returns {line, busy, done}.
  function automatic logic [2:0] chan_model(input int p, input int h, input int b, input int t);
    logic hi, bz, dn;
    hi = 1'b0; bz = 1'b0; dn = 1'b0;
    if (t >= 0) begin
      if (b == 0 || t < p * b) begin
        bz = 1'b1;
        hi = ((t % p) < h);
      end else begin
        dn = (t == p * b);
      end
    end
    return {hi, bz, dn};
  endfunction

  function automatic logic [4*N-1:0] exp_bank(input int t);
    logic [N-1:0] o1, o0, bz, dn;
    logic [2:0]   m;
    o1 = '0; o0 = '0; bz = '0; dn = '0;
    for (int c = 0; c < N; c++) begin
      if (cact[c]) begin
        m = chan_model(cp[c], chh[c], cb[c], t);
        o1[c] = m[2] & cbr[c];
        o0[c] = m[2] & ~cbr[c];
        bz[c] = m[1];
        dn[c] = m[0];
      end
    end
    return {o1, o0, bz, dn};
  endfunction

  task automatic write_cfg(input int ch, input int p, input int h, input int b);
    @(negedge clk_100Mz);
    cfg_wr     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = CW'(p);
    cfg_high   = CW'(h);
    cfg_burst  = BW'(b);
    @(negedge clk_100Mz);
    cfg_wr     = 1'b0;
  endtask

  task automatic set_model(input int ch, input int p, input int h, input int b, input logic br);
    cp[ch]  = p;
    chh[ch] = h;
    cb[ch]  = b;
    cbr[ch] = br;
  endtask

  task automatic test_reset();
    logic [4*N-1:0] obs;
    enable_channel = 4'b1111;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_100Mz);
    obs = {data_out_1, data_out_0, busy, done};
    checks++;
    if (obs !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs, 16'h0000);
    end
    rst_n = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      @(negedge clk_100Mz);
      obs = {data_out_1, data_out_0, busy, done};
      checks++;
      if (obs !== 16'h0000) begin
        failures++;
        $display("FAIL reset_no_start s=%0d got=%h exp=%h", s, obs, 16'h0000);
      end
    end
    enable_channel = 4'b0000;
    repeat (2) @(negedge clk_100Mz);
  endtask

  task automatic test_burst_branch1();
    logic [4*N-1:0] obs, exp;
    write_cfg(0, 10, 3, 4);
    set_model(0, 10, 3, 4, 1'b1);
    cact = 4'b0001;
    branch_channel = 4'b0001;
    enable_channel[0] = 1'b1;
    for (int s = 1; s <= 46; s++) begin
      @(negedge clk_100Mz);
      obs = {data_out_1, data_out_0, busy, done};
      exp = exp_bank(s - 2);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL burst_branch1 s=%0d got=%h exp=%h", s, obs, exp);
      end
    end
    enable_channel[0] = 1'b0;
    repeat (2) @(negedge clk_100Mz);
  endtask

  task automatic test_continuous_disable();
    logic [4*N-1:0] obs, exp;
    write_cfg(1, 5, 2, 0);
    set_model(1, 5, 2, 0, 1'b0);
    cact = 4'b0010;
    branch_channel = 4'b0000;
    enable_channel[1] = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      @(negedge clk_100Mz);
      obs = {data_out_1, data_out_0, busy, done};
      exp = exp_bank(s - 2);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL continuous_disable s=%0d got=%h exp=%h", s, obs, exp);
      end
      if (s == 12) enable_channel[1] = 1'b0;
      if (s == 13) cact = 4'b0000;
    end
    repeat (2) @(negedge clk_100Mz);
  endtask

  task automatic test_high_extremes();
    logic [4*N-1:0] obs, exp;
    int hv;
    for (int k = 0; k < 2; k++) begin
      hv = (k == 0) ? 0 : 12;
      write_cfg(2, 8, hv, 2);
      set_model(2, 8, hv, 2, 1'b1);
      cact = 4'b0100;
      branch_channel = 4'b0100;
      enable_channel[2] = 1'b1;
      for (int s = 1; s <= 20; s++) begin
        @(negedge clk_100Mz);
        obs = {data_out_1, data_out_0, busy, done};
        exp = exp_bank(s - 2);
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL high_extreme h=%0d s=%0d got=%h exp=%h", hv, s, obs, exp);
        end
      end
      enable_channel[2] = 1'b0;
      repeat (2) @(negedge clk_100Mz);
    end
  endtask

  task automatic test_midburst_changes();
    logic [4*N-1:0] obs, exp;
    write_cfg(3, 6, 2, 3);
    set_model(3, 6, 2, 3, 1'b0);
    cact = 4'b1000;
    branch_channel = 4'b0000;
    enable_channel[3] = 1'b1;
    for (int s = 1; s <= 22; s++) begin
      @(negedge clk_100Mz);
      obs = {data_out_1, data_out_0, busy, done};
      exp = exp_bank(s - 2);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL midburst_hold s=%0d got=%h exp=%h", s, obs, exp);
      end
      if (s == 5) begin
        branch_channel[3] = 1'b1;
        cfg_wr = 1'b1; cfg_ch = 2'd3;
        cfg_period = 16'd4; cfg_high = 16'd1; cfg_burst = 8'd2;
      end
      if (s == 6) cfg_wr = 1'b0;
    end
    enable_channel[3] = 1'b0;
    repeat (2) @(negedge clk_100Mz);
    set_model(3, 4, 1, 2, 1'b1);
    enable_channel[3] = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      @(negedge clk_100Mz);
      obs = {data_out_1, data_out_0, busy, done};
      exp = exp_bank(s - 2);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL midburst_next s=%0d got=%h exp=%h", s, obs, exp);
      end
    end
    enable_channel[3] = 1'b0;
    repeat (2) @(negedge clk_100Mz);
  endtask

  task automatic test_back_to_back();
    logic [4*N-1:0] obs, exp;
    write_cfg(0, 4, 2, 2);
    set_model(0, 4, 2, 2, 1'b1);
    cact = 4'b0001;
    branch_channel = 4'b0001;
    for (int rep = 0; rep < 2; rep++) begin
      enable_channel[0] = 1'b1;
      for (int s = 1; s <= 20; s++) begin
        @(negedge clk_100Mz);
        obs = {data_out_1, data_out_0, busy, done};
        exp = exp_bank(s - 2);
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL back_to_back rep=%0d s=%0d got=%h exp=%h", rep, s, obs, exp);
        end
      end
      enable_channel[0] = 1'b0;
      @(negedge clk_100Mz);
    end
    @(negedge clk_100Mz);
  endtask

  task automatic test_four_channels();
    logic [4*N-1:0] obs, exp;
    write_cfg(1, 5, 2, 2);
    write_cfg(1, 0, 4, 1);
    write_cfg(0, 3, 1, 3);
    write_cfg(2, 7, 3, 1);
    write_cfg(3, 2, 1, 5);
    set_model(0, 3, 1, 3, 1'b1);
    set_model(1, 5, 2, 2, 1'b0);
    set_model(2, 7, 3, 1, 1'b0);
    set_model(3, 2, 1, 5, 1'b1);
    cact = 4'b1111;
    branch_channel = 4'b1001;
    enable_channel = 4'b1111;
    cfg_wr = 1'b1; cfg_ch = 2'd0;
    cfg_period = 16'd9; cfg_high = 16'd9; cfg_burst = 8'd1;
    for (int s = 1; s <= 16; s++) begin
      @(negedge clk_100Mz);
      cfg_wr = 1'b0;
      obs = {data_out_1, data_out_0, busy, done};
      exp = exp_bank(s - 2);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL four_channels s=%0d got=%h exp=%h", s, obs, exp);
      end
    end
    enable_channel = 4'b0000;
    repeat (2) @(negedge clk_100Mz);
    set_model(0, 9, 9, 1, 1'b1);
    cact = 4'b0001;
    enable_channel[0] = 1'b1;
    for (int s = 1; s <= 13; s++) begin
      @(negedge clk_100Mz);
      obs = {data_out_1, data_out_0, busy, done};
      exp = exp_bank(s - 2);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL same_edge_write s=%0d got=%h exp=%h", s, obs, exp);
      end
    end
    enable_channel[0] = 1'b0;
    repeat (2) @(negedge clk_100Mz);
  endtask

  task automatic test_reset_midburst();
    logic [4*N-1:0] obs;
    write_cfg(2, 6, 3, 4);
    branch_channel = 4'b0000;
    enable_channel[2] = 1'b1;
    repeat (5) @(negedge clk_100Mz);
    rst_n = 1'b0;
    @(negedge clk_100Mz);
    rst_n = 1'b1;
    for (int s = 1; s <= 30; s++) begin
      obs = {data_out_1, data_out_0, busy, done};
      checks++;
      if (obs !== 16'h0000) begin
        failures++;
        $display("FAIL reset_midburst s=%0d got=%h exp=%h", s, obs, 16'h0000);
      end
      @(negedge clk_100Mz);
    end
    enable_channel[2] = 1'b0;
    repeat (2) @(negedge clk_100Mz);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_wr = 1'b0;
    cfg_ch = 2'd0;
    cfg_period = 16'd0;
    cfg_high = 16'd0;
    cfg_burst = 8'd0;
    branch_channel = 4'b0000;
    enable_channel = 4'b0000;
    cbr = 4'b0000;
    cact = 4'b0000;
    for (int c = 0; c < N; c++) begin
      cp[c] = 2; chh[c] = 1; cb[c] = 0;
    end
    test_reset();
    test_burst_branch1();
    test_continuous_disable();
    test_high_extremes();
    test_midburst_changes();
    test_back_to_back();
    test_four_channels();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
